abro_stim_driver: RTL and testbench

Stimulus-side companion for the ABRO recognizer: stores a short programmed sequence of (A, B, hold) steps, plays it onto the recognizer's A/B inputs cycle by cycle, and monitors the recognizer's O output. It reports whether O was seen, the cycle it first appeared, and pass/fail against an expected result. It sits in the ABRO test harness, driving the recognizer and feeding a self-checking bench or on-chip BIST controller.

---
 rtl/abro_stim_driver.sv | 201 ++++++++++++++++++++
 tb/tb_abro_stim_driver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/abro_stim_driver.sv
// Stimulus driver for the ABRO recognizer: plays a stored (A, B, hold) sequence and scores O.
// Define ABRO_DRV_ABORT_EN to add the abort input that ends a run early with pass=0.
module abro_stim_driver #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DRAIN_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic       load_a,
  input  logic       load_b,
  input  logic [3:0] load_hold,
  input  logic       start,
  input  logic       expect_o,
  output logic       A,
  output logic       B,
  input  logic       O,
  output logic       busy,
  output logic       done,
  output logic       o_seen,
  output logic [7:0] o_cycle,
  output logic       pass
`ifdef ABRO_DRV_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [7:0]  DrainLast = 8'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [7:0]        drain_q, drain_d;
  logic [7:0]        run_q, run_d;
  logic              a_q, a_d, b_q, b_d;
  logic              expect_q, expect_d;
  logic              o_seen_q, o_seen_d;
  logic [7:0]        o_cycle_q, o_cycle_d;
  logic              pass_q, pass_d;
  logic              aborted_q, aborted_d;

  logic [DEPTH-1:0]  mem_a, mem_b;
  logic [3:0]        mem_hold [DEPTH];

  logic abort_req;
`ifdef ABRO_DRV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  logic load_fire, start_fire, sample_o, step_end, last_step;
  logic [IdxW-1:0] idx_next;

  assign busy       = (state_q == StPlay) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  assign load_ready = (state_q == StIdle) && (count_q < CntW'(DEPTH)) && !start;
  // clear wins over both load and start when they coincide
  assign load_fire  = load_valid && load_ready && !clear;
  assign start_fire = (state_q == StIdle) && start && !clear && (count_q != '0);
  // Once aborted, the trailing idle cycle no longer captures O
  assign sample_o   = busy && O && !o_seen_q && !aborted_q;
  assign step_end   = (hold_cnt_q == mem_hold[idx_q]);
  assign last_step  = (({1'b0, idx_q} + CntW'(1)) == count_q);
  assign idx_next   = idx_q + IdxW'(1);

  assign A       = a_q;
  assign B       = b_q;
  assign o_seen  = o_seen_q;
  assign o_cycle = o_cycle_q;
  assign pass    = pass_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    drain_d    = drain_q;
    run_d      = (busy && run_q != 8'hFF) ? run_q + 8'd1 : run_q;
    a_d        = a_q;
    b_d        = b_q;
    expect_d   = expect_q;
    o_seen_d   = o_seen_q | sample_o;
    o_cycle_d  = sample_o ? run_q : o_cycle_q;
    pass_d     = pass_q;
    aborted_d  = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          count_d = '0;
        end else if (load_fire) begin
          count_d = count_q + CntW'(1);
        end
        if (start_fire) begin
          state_d    = StPlay;
          expect_d   = expect_o;
          o_seen_d   = 1'b0;
          o_cycle_d  = 8'hFF;
          run_d      = 8'd0;
          idx_d      = '0;
          hold_cnt_d = 4'd0;
          pass_d     = 1'b0;
          aborted_d  = 1'b0;
          a_d        = mem_a[0];
          b_d        = mem_b[0];
        end
      end
      StPlay: begin
        if (abort_req) begin
          // One more A=B=0 cycle via the final drain slot, then DONE
          state_d   = StDrain;
          drain_d   = DrainLast;
          aborted_d = 1'b1;
          a_d       = 1'b0;
          b_d       = 1'b0;
        end else if (step_end) begin
          hold_cnt_d = 4'd0;
          if (last_step) begin
            state_d = StDrain;
            drain_d = 8'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            idx_d = idx_next;
            a_d   = mem_a[idx_next];
            b_d   = mem_b[idx_next];
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      StDrain: begin
        if (abort_req && !aborted_q) begin
          drain_d   = DrainLast;
          aborted_d = 1'b1;
        end else if (drain_q == DrainLast) begin
          state_d = StDone;
          pass_d  = aborted_q ? 1'b0 : (o_seen_d == expect_q);
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      hold_cnt_q <= 4'd0;
      drain_q    <= 8'd0;
      run_q      <= 8'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      expect_q   <= 1'b0;
      o_seen_q   <= 1'b0;
      o_cycle_q  <= 8'hFF;
      pass_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      drain_q    <= drain_d;
      run_q      <= run_d;
      a_q        <= a_d;
      b_q        <= b_d;
      expect_q   <= expect_d;
      o_seen_q   <= o_seen_d;
      o_cycle_q  <= o_cycle_d;
      pass_q     <= pass_d;
      aborted_q  <= aborted_d;
    end
  end

  // Sequence storage needs no reset; count_q alone defines valid entries
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_a[count_q[IdxW-1:0]]    <= load_a;
      mem_b[count_q[IdxW-1:0]]    <= load_b;
      mem_hold[count_q[IdxW-1:0]] <= load_hold;
    end
  end

endmodule

// File: tb/tb_abro_stim_driver.sv
// Self-checking bench for abro_stim_driver: directed plan scenarios plus randomized sequences
// scored against a trace model built from the step list.
module tb_abro_stim_driver;
  localparam int DEPTH = 8;
  localparam int DRAIN = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0, load_valid = 1'b0, load_a = 1'b0, load_b = 1'b0;
  logic [3:0] load_hold = 4'd0;
  logic       start = 1'b0, expect_o = 1'b0, O = 1'b0, abort = 1'b0;
  logic       load_ready, A, B, busy, done, o_seen, pass;
  logic [7:0] o_cycle;

  abro_stim_driver #(.DEPTH(DEPTH), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
    .load_a(load_a), .load_b(load_b), .load_hold(load_hold), .start(start), .expect_o(expect_o),
    .A(A), .B(B), .O(O), .busy(busy), .done(done), .o_seen(o_seen), .o_cycle(o_cycle),
    .pass(pass)
`ifdef ABRO_DRV_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit ma[$], mb[$];
  int mh[$];
  bit o_pat[1024];

  task automatic o_none();
    for (int i = 0; i < 1024; i++) o_pat[i] = 1'b0;
  endtask

  // Called #1 after a rising edge; leaves inputs idle #1 after the next edge
  task automatic do_load(input bit a, input bit b, input int h, input bit exp_rdy);
    load_valid = 1'b1; load_a = a; load_b = b; load_hold = 4'(h);
    @(negedge clk);
    tests++;
    if (load_ready !== exp_rdy) begin
      fails++; $display("FAIL load_ready: got %b want %b", load_ready, exp_rdy);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    if (exp_rdy) begin ma.push_back(a); mb.push_back(b); mh.push_back(h); end
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ma.delete(); mb.delete(); mh.delete();
  endtask

  task automatic load_plan();
    do_load(1, 1, 0, 1); do_load(1, 0, 0, 1); do_load(0, 1, 0, 1); do_load(1, 1, 1, 1);
  endtask

  task automatic run_check(input bit exp_o, input string name);
    bit ea[$], eb[$];
    int first = -1;
    bit seen, exp_pass;
    logic [7:0] exp_cyc;
    foreach (ma[i]) for (int j = 0; j <= mh[i]; j++) begin ea.push_back(ma[i]); eb.push_back(mb[i]); end
    for (int j = 0; j < DRAIN; j++) begin ea.push_back(1'b0); eb.push_back(1'b0); end
    for (int k = 0; k < ea.size(); k++) if (o_pat[k] && first < 0) first = k;
    seen     = (first >= 0);
    exp_cyc  = !seen ? 8'hFF : (first > 255 ? 8'hFF : 8'(first));
    exp_pass = (seen == exp_o);
    expect_o = exp_o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < ea.size(); k++) begin
      O = o_pat[k];
      @(negedge clk);
      tests++;
      if (busy !== 1'b1 || A !== ea[k] || B !== eb[k] || done !== 1'b0) begin
        fails++;
        $display("FAIL %s cycle %0d: busy/A/B/done got %b%b%b%b want 1%b%b0", name, k, busy, A, B,
                 done, ea[k], eb[k]);
      end
      @(posedge clk); #1;
    end
    O = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || A !== 1'b0 || B !== 1'b0) begin
      fails++; $display("FAIL %s end: done/busy/A/B got %b%b%b%b want 1000", name, done, busy, A, B);
    end
    tests++;
    if (o_seen !== seen || o_cycle !== exp_cyc || pass !== exp_pass) begin
      fails++;
      $display("FAIL %s result: o_seen/o_cycle/pass got %b/%0d/%b want %b/%0d/%b", name, o_seen,
               o_cycle, pass, seen, exp_cyc, exp_pass);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || pass !== exp_pass) begin
      fails++; $display("FAIL %s after: done/pass got %b%b want 0%b", name, done, pass, exp_pass);
    end
  endtask

  task automatic expect_no_run(input string name);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL %s: busy/done got %b%b want 00", name, busy, done);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (A !== 0 || B !== 0 || busy !== 0 || done !== 0 || o_seen !== 0 || pass !== 0 ||
        o_cycle !== 8'hFF || load_ready !== 1) begin
      fails++;
      $display("FAIL reset: A B busy done o_seen pass o_cycle load_ready got %b%b%b%b%b%b %h %b",
               A, B, busy, done, o_seen, pass, o_cycle, load_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_plan();
    clear_buf(); load_plan(); o_none(); o_pat[5] = 1'b1;
    run_check(1'b1, "plan_o5");
    o_none();
    run_check(1'b0, "plan_no_o_exp0");
    run_check(1'b1, "plan_no_o_exp1");
  endtask

  task automatic test_full();
    clear_buf();
    for (int i = 0; i < DEPTH; i++) do_load(1'($urandom), 1'($urandom), $urandom_range(0, 3), 1);
    do_load(1, 1, 15, 0);
    o_none();
    run_check(1'b0, "full8");
    clear_buf();
    @(negedge clk);
    tests++;
    if (load_ready !== 1'b1) begin
      fails++; $display("FAIL clear_ready: got %b want 1", load_ready);
    end
    start = 1'b1;
    @(negedge clk);
    tests++;
    if (load_ready !== 1'b0) begin
      fails++; $display("FAIL start_blocks_load: got %b want 0", load_ready);
    end
    @(posedge clk); #1;
    start = 1'b0;
    expect_no_run("start_empty");
    clear = 1'b1; load_valid = 1'b1; load_a = 1'b1; load_b = 1'b1; load_hold = 4'd2;
    @(posedge clk); #1;
    clear = 1'b0; load_valid = 1'b0;
    expect_no_run("clear_beats_load");
  endtask

  task automatic test_single();
    clear_buf(); do_load(1, 0, 15, 1);
    o_none(); o_pat[3] = 1'b1; o_pat[20] = 1'b1;
    run_check(1'b1, "single_h15");
  endtask

  task automatic test_reset_mid();
    clear_buf(); load_plan(); o_none();
    expect_o = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; O = 1'b1;
    @(posedge clk); #1;
    O = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++;
    if (A !== 0 || B !== 0 || busy !== 0 || o_cycle !== 8'hFF || o_seen !== 0) begin
      fails++;
      $display("FAIL reset_mid: A B busy o_seen o_cycle got %b%b%b%b %h want 0000 ff", A, B, busy,
               o_seen, o_cycle);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    ma.delete(); mb.delete(); mh.delete();
    expect_no_run("start_after_reset");
    load_plan(); o_none(); o_pat[2] = 1'b1;
    run_check(1'b1, "reload_after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      clear_buf();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) do_load(1'($urandom), 1'($urandom), $urandom_range(0, 15), 1);
      o_none();
      if (it % 3 != 0) for (int k = 0; k < 300; k++) o_pat[k] = ($urandom_range(0, 24) == 0);
      run_check(1'($urandom), "random");
    end
  endtask

`ifdef ABRO_DRV_ABORT_EN
  task automatic test_abort();
    clear_buf(); load_plan(); o_none();
    expect_o = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if (A !== 0 || B !== 0 || done !== 0) begin
      fails++; $display("FAIL abort_cycle3: A B done got %b%b%b want 000", A, B, done);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1 || pass !== 0 || busy !== 0) begin
      fails++; $display("FAIL abort_done: done pass busy got %b%b%b want 100", done, pass, busy);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    test_reset();
    test_plan();
    test_full();
    test_single();
    test_reset_mid();
    test_random();
`ifdef ABRO_DRV_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
